// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Sequences the IF/ID, ID/EX, EX/MA and MA/WB buffers and the PC. It handles
//   three kinds of hazard:
//     - load-use in decode: inserts one bubble.
//     - taken branch/jump resolved in EX: flushes fetch for BRANCH_PENALTY cycles.
//     - multi-cycle data-memory access in MA: freezes the whole pipe.
//   It also keeps a saturating count of the cycles in which the PC was held.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   id_rs1/id_rs2         decode source registers, id_uses_rs1/2 read flags
//   ex_rd, ex_is_load,    EX destination and instruction kind
//   ex_reg_write
//   ex_branch_taken       taken branch/jump resolved in EX this cycle
//   ma_mem_req/ready      MA data-memory handshake
//   pc_en, *_en           PC and buffer load enables (combinational)
//   if_id/id_ex_flush     load a NOP bubble into the buffer
//   ctrl_state            FSM state (RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3)
//   stall_cycles          saturating count of cycles with pc_en=0
module pipeline_hazard_controller #(
    parameter int REG_W          = 5,
    parameter int BRANCH_PENALTY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_reg_write,
    input  logic             ex_branch_taken,
    input  logic             ma_mem_req,
    input  logic             ma_mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_ma_en,
    output logic             ma_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       ctrl_state,
    output logic [15:0]      stall_cycles
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(BRANCH_PENALTY - 1);

    state_t     state, state_nx;
    logic [3:0] fcnt, fcnt_nx;
    // Set when MEM_WAIT was entered from FLUSH, so the remaining
    // fetch-flush cycles resume once memory completes.
    logic       resume_flush, resume_nx;

    logic mem_stall, load_use;
    logic mode_flush, freeze, lu_eff;

    assign mem_stall = ma_mem_req & ~ma_mem_ready;
    assign load_use  = ex_is_load & ex_reg_write & (ex_rd != '0) &
                       ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                        (id_uses_rs2 & (id_rs2 == ex_rd)));

    always_comb begin
        // Flush-mode arms apply in FLUSH, and in MEM_WAIT if it was entered from FLUSH.
        mode_flush = (state == FLUSH) || ((state == MEM_WAIT) && resume_flush);
        // In MEM_WAIT only the ready flag matters; the request is known to be pending.
        freeze     = (state == MEM_WAIT) ? ~ma_mem_ready : mem_stall;
        // LOAD_STALL suppresses load_use so each load costs exactly one bubble.
        // During a fetch flush, decode holds a bubble and cannot cause a hazard.
        lu_eff     = load_use && (state != LOAD_STALL) && !mode_flush;

        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_ma_en    = 1'b1;
        ma_wb_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        state_nx    = RUN;
        fcnt_nx     = fcnt;
        resume_nx   = 1'b0;

        if (rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_ma_en    = 1'b0;
            ma_wb_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            fcnt_nx     = '0;
        end else if (freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_ma_en  = 1'b0;
            ma_wb_en  = 1'b0;
            state_nx  = MEM_WAIT;
            resume_nx = mode_flush;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (BRANCH_PENALTY > 1) begin
                fcnt_nx  = FLUSH_LOAD;
                state_nx = FLUSH;
            end
        end else if (mode_flush) begin
            if_id_flush = 1'b1;
            fcnt_nx     = (fcnt != '0) ? fcnt - 4'd1 : '0;
            state_nx    = (fcnt > 4'd1) ? FLUSH : RUN;
        end else if (lu_eff) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            state_nx    = LOAD_STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            fcnt         <= '0;
            resume_flush <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state        <= state_nx;
            fcnt         <= fcnt_nx;
            resume_flush <= resume_nx;
            if (!pc_en && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
        end
    end

    assign ctrl_state = state;

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the inter-stage pipeline buffers (IF/ID, ID/EX, EX/MA, MA/WB) and the PC register of the RISC core.
- Detects load-use hazards, taken branches/jumps resolved in EX, and multi-cycle data-memory waits in MA.
- Drives per-buffer load enables and bubble-insert (flush) controls, and keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
REG_W, 5, register-index width of rs1/rs2/rd fields
BRANCH_PENALTY, 2, total fetch-bubble cycles after a taken branch (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_rs1  in  REG_W  source register 1 of the instruction in decode
id_rs2  in  REG_W  source register 2 of the instruction in decode
id_uses_rs1  in  1  decode instruction reads rs1
id_uses_rs2  in  1  decode instruction reads rs2
ex_rd  in  REG_W  destination register of the instruction in EX
ex_is_load  in  1  EX instruction is a load
ex_reg_write  in  1  EX instruction writes the register file
ex_branch_taken  in  1  taken branch/jump resolved in EX this cycle
ma_mem_req  in  1  MA stage is accessing data memory
ma_mem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC load enable
if_id_en, id_ex_en, ex_ma_en, ma_wb_en  out  1 each  buffer load enables
if_id_flush, id_ex_flush  out  1 each  load a NOP bubble into the buffer (overrides its data)
ctrl_state  out  2  current FSM state encoding
stall_cycles  out  16  saturating count of cycles with pc_en=0

Behaviour:
- FSM states: RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3. State register and counters update on rising clk.
- Enables and flushes are combinational from the current state and current inputs, so a stall takes effect in the same cycle.
- rst=1: next state RUN, flush counter 0, stall_cycles 0. While rst=1, all enables are 0 and both flushes are 1.
- Default "go" vector: all enables 1, flushes 0.
- mem_stall = ma_mem_req & ~ma_mem_ready.
- load_use = ex_is_load & ex_reg_write & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority in RUN, highest first: mem_stall > ex_branch_taken > load_use > go.
  - mem_stall: all enables 0, flushes 0. Next state MEM_WAIT.
  - branch: go vector plus if_id_flush=1 and id_ex_flush=1. If BRANCH_PENALTY=1, next state RUN; otherwise load flush counter with BRANCH_PENALTY-1 and go to FLUSH.
  - load_use: pc_en=0, if_id_en=0, id_ex_flush=1, ex_ma_en=1, ma_wb_en=1. Next state LOAD_STALL.
  - none of the above: go vector. Stay in RUN.
- LOAD_STALL: same evaluation as RUN, but load_use is forced to 0. This guarantees exactly one bubble per load. Unless another arm fires, next state is RUN.
- MEM_WAIT:
  - While ma_mem_ready=0: all enables 0, flushes 0. Stay in MEM_WAIT.
  - On ma_mem_ready=1: evaluate the RUN arms with mem_stall=0, including a branch or load_use held frozen in EX, and take that arm's next state.
- FLUSH:
  - mem_stall: freeze (all enables 0), hold the counter, go to MEM_WAIT, then resume FLUSH with the remaining count.
  - Otherwise: go vector with if_id_flush=1. Decrement the counter; when it reaches 0, return to RUN.
  - A new ex_branch_taken in FLUSH reloads the counter and also asserts id_ex_flush.
- stall_cycles increments when rst=0 and pc_en=0, and saturates at 0xFFFF without wrapping.
- Reset mid-stall (any state) returns to RUN on the next edge. No pending flush count survives reset.

Test Plan:
- Reset then idle, no hazards: after rst released, all enables 1, flushes 0, ctrl_state=0, stall_cycles stays 0.
- Load-use: ex_is_load=1, ex_reg_write=1, ex_rd=5, id_uses_rs2=1, id_rs2=5 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle go vector; stall_cycles=1. Same stimulus with ex_rd=0 → no stall.
- Taken branch, BRANCH_PENALTY=2: ex_branch_taken pulse → cycle 0 if_id_flush=id_ex_flush=1; cycle 1 if_id_flush=1 only; cycle 2 RUN with flushes 0.
- Memory wait: ma_mem_req=1, ma_mem_ready=0 for 3 cycles then 1 → 3 cycles all enables 0 with ctrl_state=2, then go vector; stall_cycles=3.
- Simultaneous events: mem_stall + ex_branch_taken + load_use in one cycle → freeze first; on ready, branch flush wins with no load bubble; then 1 FLUSH cycle.
- Saturation and reset: hold mem_stall for 70000 cycles → stall_cycles=0xFFFF. Assert rst mid-FLUSH → next cycle ctrl_state=0 and stall_cycles=0.
